// File: rtl/img_sram_pkg.sv
// Shared types and helpers for the banked image SRAM controller.
// Holds the FSM state and macro-op enums plus the row/col to bank/address split.
package img_sram_pkg;

   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      IDLE,
      BURST
   } img_sram_state_e;

   typedef enum logic [1:0] {
      HOLD,
      READ,
      WRITE
   } img_sram_op_e;

   // Bank index = the row bits above the per-macro row field.
   function automatic logic [31:0] coord_bank(input logic [31:0] row,
                                              input int          brow_w,
                                              input int          bank_w);
      return (row >> brow_w) & ((32'd1 << bank_w) - 32'd1);
   endfunction

   // Macro address = {row bits inside the macro, column bits}.
   function automatic logic [31:0] coord_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          brow_w,
                                              input int          col_w);
      logic [31:0] brow_mask;
      logic [31:0] col_mask;
      brow_mask = (32'd1 << brow_w) - 32'd1;
      col_mask  = (32'd1 << col_w) - 32'd1;
      return ((row & brow_mask) << col_w) | (col & col_mask);
   endfunction

endpackage

// File: rtl/img_sram_bank.sv
// One bank of the image store: wraps a single sram_compiled_array and turns the
// abstract macro op into the we/sense pin encoding.
module img_sram_bank
   import img_sram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  img_sram_op_e      op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o
);

   logic we;
   logic sense;

   // Op decode: anything that is not READ or WRITE parks the macro in HOLD.
   // NOTE: both outputs get a default before the case so no path leaves them
   // unassigned, which would infer a latch.
   always_comb begin
      we    = 1'b0;
      sense = 1'b1;
      unique case (op_i)
         WRITE:   we    = 1'b1;
         READ:    sense = 1'b0;
         default: ;
      endcase
   end

   sram_compiled_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_macro (
      .clk   (clk),
      .we    (we),
      .sense (sense),
      .addr  (addr_i),
      .din   (din_i),
      .dout  (dout_o)
   );

endmodule

// File: rtl/sram_compiled_array.sv
// Behavioural stand-in for the compiled SRAM macro.
// Pins: we/sense select WRITE (1/1), READ (0/0) or HOLD (0/1); the array acts on
// the falling edge so that posedge-registered address/control are stable for it.
module sram_compiled_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic              sense,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Low-phase array access; dout only changes on a READ and holds otherwise.
   // NOTE: the storage array has no reset -- real macros do not clear, and a reset
   // port on a memory would force it into flops.
   always_ff @(negedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end else if (!sense) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/img_sram_banked_ctrl.sv
// Banked image SRAM controller: valid/ready request port, single-pixel writes,
// raster burst reads and a registered response with backpressure.
// Optional build macro IMG_SRAM_ZERO_PAD_EN: out-of-image beats skip the macro and
// return zero; out-of-image writes are dropped. Without it coordinates wrap modulo.
module img_sram_banked_ctrl
   import img_sram_pkg::*;
#(
   parameter  int DATA_W    = DATA_W_DEF,
   parameter  int NUM_BANKS = 4,
   parameter  int BANK_ROWS = 64,
   parameter  int COLS      = 256,
   parameter  int LEN_W     = 16,
   localparam int ROWS      = NUM_BANKS * BANK_ROWS,
   localparam int ROW_W     = $clog2(ROWS),
   localparam int COL_W     = $clog2(COLS),
   localparam int CRD_W     = ((ROW_W > COL_W) ? ROW_W : COL_W) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic signed [CRD_W-1:0] req_row,
   input  logic signed [CRD_W-1:0] req_col,
   input  logic [LEN_W-1:0]        req_len,
   input  logic [DATA_W-1:0]       req_din,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_last,
   output logic                    busy
);

   localparam int BROW_W = $clog2(BANK_ROWS);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int ADDR_W = BROW_W + COL_W;

   img_sram_state_e          state_q, state_d;
   logic signed [CRD_W-1:0]  row_q, col_q;
   logic [LEN_W-1:0]         rem_q;
   img_sram_op_e             op_q;
   logic [BANK_W-1:0]        bank_q;
   logic [ADDR_W-1:0]        addr_q;
   logic [DATA_W-1:0]        din_q;
   logic                     pend_q, pend_pad_q, pend_last_q;
   logic                     rsp_valid_q, rsp_last_q;
   logic [DATA_W-1:0]        rsp_data_q;
   logic [DATA_W-1:0]        bank_dout [NUM_BANKS];

   logic                     slot_free, accept, issue;
   logic                     beat_we, beat_last, beat_pad;
   logic signed [CRD_W-1:0]  beat_row, beat_col, next_row, next_col;
   logic [BANK_W-1:0]        beat_bank;
   logic [ADDR_W-1:0]        beat_addr;

   // Output slot is free when the response register is empty or being drained.
   assign slot_free = ~rsp_valid_q | rsp_ready;

   // FSM state register.
   // NOTE: clocked state uses non-blocking assignment so every flop samples the
   // pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a multi-beat read enters BURST, the final issue returns to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (accept && !req_we && req_len != '0) state_d = BURST;
         BURST: if (slot_free && rem_q == LEN_W'(1))    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: request handshake, issue strobe and the coordinates of this beat.
   always_comb begin
      req_ready = 1'b0;
      accept    = 1'b0;
      issue     = 1'b0;
      beat_we   = 1'b0;
      beat_last = 1'b0;
      beat_row  = row_q;
      beat_col  = col_q;
      unique case (state_q)
         IDLE: begin
            req_ready = ~rst & slot_free;
            accept    = req_valid & req_ready;
            issue     = accept;
            beat_we   = req_we;
            beat_last = (req_len == '0);
            beat_row  = req_row;
            beat_col  = req_col;
         end
         BURST: begin
            issue     = slot_free;
            beat_last = (rem_q == LEN_W'(1));
         end
         default: ;
      endcase
   end

   // Raster walk to the following pixel plus the bank/address split of this beat.
   always_comb begin
      if (int'(beat_col) == COLS - 1) begin
         next_col = '0;
         next_row = beat_row + CRD_W'(1);
      end else begin
         next_col = beat_col + CRD_W'(1);
         next_row = beat_row;
      end
      beat_bank = BANK_W'(coord_bank(32'(beat_row), BROW_W, BANK_W));
      beat_addr = ADDR_W'(coord_addr(32'(beat_row), 32'(beat_col), BROW_W, COL_W));
   end

`ifdef IMG_SRAM_ZERO_PAD_EN
   assign beat_pad = (int'(beat_row) < 0) || (int'(beat_row) >= ROWS) ||
                     (int'(beat_col) < 0) || (int'(beat_col) >= COLS);
`else
   assign beat_pad = 1'b0;
`endif

   // Datapath: macro issue registers, burst walker/counter, pending read and response.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q       <= '0;
         col_q       <= '0;
         rem_q       <= '0;
         op_q        <= HOLD;
         bank_q      <= '0;
         addr_q      <= '0;
         din_q       <= '0;
         pend_q      <= 1'b0;
         pend_pad_q  <= 1'b0;
         pend_last_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         op_q <= HOLD;
         if (issue) begin
            bank_q <= beat_bank;
            addr_q <= beat_addr;
            din_q  <= req_din;
            if (beat_pad)     op_q <= HOLD;
            else if (beat_we) op_q <= WRITE;
            else              op_q <= READ;
            row_q <= next_row;
            col_q <= next_col;
            rem_q <= (state_q == IDLE) ? req_len : rem_q - LEN_W'(1);
         end
         // Capture uses bank_q from the issue edge, never the live request row.
         if (slot_free) begin
            rsp_valid_q <= pend_q;
            if (pend_q) begin
               rsp_data_q <= pend_pad_q ? '0 : bank_dout[bank_q];
               rsp_last_q <= pend_last_q;
            end else begin
               rsp_last_q <= 1'b0;
            end
            pend_q      <= issue & ~beat_we;
            pend_pad_q  <= beat_pad;
            pend_last_q <= beat_last;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      img_sram_op_e bank_op;
      assign bank_op = (bank_q == BANK_W'(b)) ? op_q : HOLD;

      img_sram_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk    (clk),
         .op_i   (bank_op),
         .addr_i (addr_q),
         .din_i  (din_q),
         .dout_o (bank_dout[b])
      );
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;
   assign busy      = (state_q != IDLE) | rsp_valid_q;

endmodule

// File: tb/tb_img_sram_banked_ctrl.sv
// Directed bench for img_sram_banked_ctrl (default geometry: 4 banks x 64 rows x 256 cols).
// Honours IMG_SRAM_ZERO_PAD_EN so the same bench covers both builds.
module tb_img_sram_banked_ctrl;
   import img_sram_pkg::*;

   localparam int CRD_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [CRD_W-1:0] req_row;
   logic [CRD_W-1:0] req_col;
   logic [15:0]      req_len;
   logic [7:0]       req_din;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [7:0]       rsp_data;
   logic             rsp_last;
   logic             busy;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] got_data [$];
   logic       got_last [$];
   int         stall_err;
   int         bubbles;

   always #5 clk = ~clk;

   img_sram_banked_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_row   (req_row),
      .req_col   (req_col),
      .req_len   (req_len),
      .req_din   (req_din),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_last  (rsp_last),
      .busy      (busy)
   );

   // Present one request and hold it until accepted; returns just after the accepting edge.
   task automatic send_req(input bit we, input int r, input int c, input int len,
                           input logic [7:0] d);
      int cyc = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_row   = CRD_W'(r);
      req_col   = CRD_W'(c);
      req_len   = 16'(len);
      req_din   = d;
      while (req_ready !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL req_accept: req_ready=%b required 1 (r=%0d c=%0d)", req_ready, r, c);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Gather n response beats; toggle=1 drives rsp_ready 1,0,1,0.. and watches stalled data.
   task automatic collect(input int n, input bit toggle);
      int         cyc = 0;
      bit         prev_stall = 1'b0;
      bit         started = 1'b0;
      logic [7:0] held = '0;
      logic       held_last = 1'b0;
      got_data.delete();
      got_last.delete();
      stall_err = 0;
      bubbles   = 0;
      while (got_data.size() < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (prev_stall && (rsp_valid !== 1'b1 || rsp_data !== held || rsp_last !== held_last))
            stall_err++;
         rsp_ready  = toggle ? cyc[0] : 1'b1;
         prev_stall = 1'b0;
         if (rsp_valid === 1'b1) begin
            started = 1'b1;
            if (rsp_ready) begin
               got_data.push_back(rsp_data);
               got_last.push_back(rsp_last);
            end else begin
               prev_stall = 1'b1;
               held       = rsp_data;
               held_last  = rsp_last;
            end
         end else if (started) begin
            bubbles++;
         end
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_row   = '0;
      req_col   = '0;
      req_len   = '0;
      req_din   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      vectors++;
      if (rsp_last !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_last: got %b want 0", rsp_last); end
      vectors++;
      if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++;
      if (dut.op_q !== HOLD) begin miscompares++; $display("FAIL reset_macro_hold: got %0d want HOLD", dut.op_q); end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_write_read();
      send_req(1'b1, 70, 3, 0, 8'hA5);
      send_req(1'b0, 70, 3, 0, 8'h00);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency_early: rsp_valid=%b want 0", rsp_valid); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL single_latency: rsp_valid=%b want 1", rsp_valid); end
      vectors++;
      if (rsp_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", rsp_data); end
      vectors++;
      if (rsp_last !== 1'b1) begin miscompares++; $display("FAIL single_last: got %b want 1", rsp_last); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
      end
      vectors++;
      if (dut.op_q !== HOLD) begin miscompares++; $display("FAIL idle_macro_hold: got %0d want HOLD", dut.op_q); end
   endtask

   task automatic test_cross_bank();
      send_req(1'b1, 63, 254, 0, 8'd1);
      send_req(1'b1, 63, 255, 0, 8'd2);
      send_req(1'b1, 64, 0, 0, 8'd3);
      send_req(1'b1, 64, 1, 0, 8'd4);
      send_req(1'b0, 63, 254, 3, 8'h00);
      collect(4, 1'b0);
      vectors++;
      if (got_data.size() != 4) begin
         miscompares++;
         $display("FAIL cross_bank_count: got %0d beats want 4", got_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_data[i] !== 8'(i + 1) || got_last[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL cross_bank_beat%0d: data=%h last=%b want %h/%b",
                        i, got_data[i], got_last[i], 8'(i + 1), (i == 3));
            end
         end
      end
      vectors++;
      if (bubbles != 0) begin miscompares++; $display("FAIL back_to_back: %0d bubbles want 0", bubbles); end
   endtask

   task automatic test_stall_toggle();
      for (int i = 0; i < 8; i++) send_req(1'b1, 10, i, 0, 8'h10 + 8'(i));
      send_req(1'b0, 10, 0, 7, 8'h00);
      collect(8, 1'b1);
      vectors++;
      if (got_data.size() != 8) begin
         miscompares++;
         $display("FAIL stall_count: got %0d beats want 8", got_data.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            vectors++;
            if (got_data[i] !== 8'h10 + 8'(i) || got_last[i] !== (i == 7)) begin
               miscompares++;
               $display("FAIL stall_beat%0d: data=%h last=%b want %h/%b",
                        i, got_data[i], got_last[i], 8'h10 + 8'(i), (i == 7));
            end
         end
      end
      vectors++;
      if (stall_err != 0) begin miscompares++; $display("FAIL stall_stable: %0d unstable cycles want 0", stall_err); end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_no_extra: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy);
      end
   endtask

   task automatic test_reset_mid_burst();
      int hs  = 0;
      int cyc = 0;
      bit hit = 1'b0;
      for (int i = 0; i < 10; i++) send_req(1'b1, 20, i, 0, 8'h30 + 8'(i));
      send_req(1'b0, 20, 0, 9, 8'h00);
      while (!hit && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid === 1'b1) begin
            if (hs == 3) begin
               hit = 1'b1;
               vectors++;
               if (rsp_data !== 8'h33) begin miscompares++; $display("FAIL midrst_beat3: got %h want 33", rsp_data); end
               rst = 1'b1;
            end else begin
               hs++;
            end
         end
      end
      vectors++;
      if (!hit) begin miscompares++; $display("FAIL midrst_timeout: saw %0d beats want 4", hs); rst = 1'b1; end
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_flush: rsp_valid=%b busy=%b req_ready=%b want 0/0/0", rsp_valid, busy, req_ready);
      end
      vectors++;
      if (dut.op_q !== HOLD) begin miscompares++; $display("FAIL midrst_hold: got %0d want HOLD", dut.op_q); end
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
      send_req(1'b0, 20, 5, 0, 8'h00);
      collect(1, 1'b0);
      vectors++;
      if (got_data.size() != 1 || got_data[0] !== 8'h35 || got_last[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_reread: beats=%0d data=%h want 1 beat of 35", got_data.size(),
                  (got_data.size() > 0) ? got_data[0] : 8'hxx);
      end
   endtask

   task automatic test_edges();
      logic [7:0] exp_first;
      logic [7:0] exp_row;
`ifdef IMG_SRAM_ZERO_PAD_EN
      exp_first = 8'h00;
      exp_row   = 8'h11;
`else
      exp_first = 8'h77;
      exp_row   = 8'hEE;
`endif
      send_req(1'b1, 0, 255, 0, 8'h77);
      send_req(1'b1, 0, 0, 0, 8'h66);
      send_req(1'b0, 0, -1, 1, 8'h00);
      collect(2, 1'b0);
      vectors++;
      if (got_data.size() != 2) begin
         miscompares++;
         $display("FAIL negcol_count: got %0d beats want 2", got_data.size());
      end else begin
         vectors++;
         if (got_data[0] !== exp_first || got_last[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL negcol_beat0: data=%h last=%b want %h/0", got_data[0], got_last[0], exp_first);
         end
         vectors++;
         if (got_data[1] !== 8'h66 || got_last[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL negcol_beat1: data=%h last=%b want 66/1", got_data[1], got_last[1]);
         end
      end
      // Row -1 aliases row 255 when wrapping; with padding the write is dropped.
      send_req(1'b1, 255, 0, 0, 8'h11);
      send_req(1'b1, -1, 0, 0, 8'hEE);
      send_req(1'b0, 255, 0, 0, 8'h00);
      collect(1, 1'b0);
      vectors++;
      if (got_data.size() != 1 || got_data[0] !== exp_row) begin
         miscompares++;
         $display("FAIL negrow_write: beats=%0d data=%h want %h", got_data.size(),
                  (got_data.size() > 0) ? got_data[0] : 8'hxx, exp_row);
      end
`ifdef IMG_SRAM_ZERO_PAD_EN
      send_req(1'b0, -1, -2, 3, 8'h00);
      collect(4, 1'b0);
      vectors++;
      if (got_data.size() != 4) begin
         miscompares++;
         $display("FAIL pad_count: got %0d beats want 4", got_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_data[i] !== 8'h00 || got_last[i] !== (i == 3)) begin
               miscompares++;
               $display("FAIL pad_beat%0d: data=%h last=%b want 00/%b", i, got_data[i], got_last[i], (i == 3));
            end
         end
      end
`endif
      @(negedge clk);
      vectors++;
      if (dut.op_q !== HOLD || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL final_idle: op=%0d busy=%b want HOLD/0", dut.op_q, busy);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_cross_bank();
      test_stall_toggle();
      test_reset_mid_burst();
      test_edges();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
